// File: rtl/spi_reg_pkg.sv
// Shared types and command-byte layout for the SPI register controller.
package spi_reg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD_WAIT,
    DECODE,
    DATA_POP,
    DATA_WAIT,
    EXEC,
    PUSH
  } state_t;

  localparam int CMD_W_BIT = 7;
  localparam int CMD_B_BIT = 6;
  localparam int ADDR_W    = 6;

  localparam logic [7:0] TX_PLACEHOLDER = 8'h00;
  localparam logic [7:0] RD_OOR         = 8'hFF;

endpackage

// File: rtl/spi_reg_bank.sv
// Register bank: NUM_REGS x 8 storage at addresses 1..NUM_REGS, read-only ID at 0.
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int         NUM_REGS = 8,
  parameter logic [7:0] ID_VALUE = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [7:0]            wr_data,
  output logic [7:0]            rd_data,
  output logic                  hit,
  output logic                  is_id,
  output logic [NUM_REGS*8-1:0] regs_flat
);

  logic [7:0] regs [1:NUM_REGS];

  assign is_id = (addr == '0);
  assign hit   = !is_id && (int'(addr) <= NUM_REGS);

  // NOTE: this is a small flop bank exposed as configuration, not a RAM, so every entry is reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i <= NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en && hit) begin
      for (int i = 1; i <= NUM_REGS; i++)
        if (addr == ADDR_W'(i)) regs[i] <= wr_data;
    end
  end

  always_comb begin
    rd_data = is_id ? ID_VALUE : RD_OOR;
    for (int i = 1; i <= NUM_REGS; i++)
      if (addr == ADDR_W'(i)) rd_data = regs[i];
  end

  for (genvar n = 1; n <= NUM_REGS; n++) begin : g_flat
    assign regs_flat[(n-1)*8 +: 8] = regs[n];
  end

endmodule

// File: rtl/spi_reg_controller.sv
// Sequences RX FIFO command/data bytes into register-bank accesses, one TX response per RX byte.
module spi_reg_controller
  import spi_reg_pkg::*;
#(
  parameter int         NUM_REGS = 8,
  parameter logic [7:0] ID_VALUE = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_empty,
  output logic                  rx_rd_en,
  output logic [7:0]            tx_data,
  input  logic                  tx_full,
  output logic                  tx_wr_en,
  output logic [NUM_REGS*8-1:0] regs_flat,
  output logic                  err,
  output logic                  busy
);

  state_t              state, next_state;
  logic                cs_n_q, cs_rise;
  logic                cmd_w, cmd_b, cmd_phase;
  logic [ADDR_W-1:0]   addr;
  logic [7:0]          data;
  logic [7:0]          rd_data;
  logic                hit, is_id;

  assign cs_rise = cs_n && !cs_n_q;

  spi_reg_bank #(.NUM_REGS(NUM_REGS), .ID_VALUE(ID_VALUE)) u_bank (
    .clk       (clk),
    .rst       (rst),
    .wr_en     ((state == EXEC) && cmd_w),
    .addr      (addr),
    .wr_data   (data),
    .rd_data   (rd_data),
    .hit       (hit),
    .is_id     (is_id),
    .regs_flat (regs_flat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cs_n_q <= 1'b1;
    end else begin
      state  <= next_state;
      cs_n_q <= cs_n;
    end
  end

  // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:      if (!rx_empty) next_state = CMD_WAIT;
      CMD_WAIT:  next_state = DECODE;
      DECODE:    next_state = PUSH;
      PUSH:      if (!tx_full) next_state = (cmd_b || (cmd_w && cmd_phase)) ? DATA_POP : IDLE;
      DATA_POP:  if (!rx_empty) next_state = DATA_WAIT;
      DATA_WAIT: next_state = EXEC;
      EXEC:      next_state = PUSH;
      default:   next_state = IDLE;
    endcase
    // Frame end wins over everything; a strobe issued this cycle still completes.
    if (cs_rise && state != IDLE) next_state = IDLE;
  end

  always_comb begin
    rx_rd_en = !rst && !rx_empty && (state == IDLE || state == DATA_POP);
    tx_wr_en = !rst && !tx_full && (state == PUSH);
    busy     = (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_w     <= 1'b0;
      cmd_b     <= 1'b0;
      cmd_phase <= 1'b0;
      addr      <= '0;
      data      <= '0;
      tx_data   <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        CMD_WAIT: begin
          cmd_w     <= rx_data[CMD_W_BIT];
          cmd_b     <= rx_data[CMD_B_BIT];
          addr      <= rx_data[ADDR_W-1:0];
          cmd_phase <= 1'b1;
        end
        DECODE: begin
          if (cmd_w) begin
            tx_data <= TX_PLACEHOLDER;
          end else begin
            tx_data <= rd_data;
            if (!hit && !is_id) err <= 1'b1;
          end
        end
        DATA_WAIT: begin
          data      <= rx_data;
          cmd_phase <= 1'b0;
        end
        EXEC: begin
          if (cmd_w) begin
            tx_data <= data;
            if (is_id)     err <= 1'b0;
            else if (!hit) err <= 1'b1;
          end else begin
            tx_data <= rd_data;
            if (!hit && !is_id) err <= 1'b1;
          end
          if (cmd_b) addr <= addr + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_controller.sv
// Directed bench: FIFO models around the controller plus a transaction-level register model.
module tb_spi_reg_controller;

  localparam int         NUM_REGS = 8;
  localparam logic [7:0] ID_VALUE = 8'hA5;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  cs_n = 1'b1;
  logic [7:0]            rx_data = 8'h00;
  logic                  rx_empty = 1'b1;
  logic                  rx_rd_en;
  logic [7:0]            tx_data;
  logic                  tx_full = 1'b0;
  logic                  tx_wr_en;
  logic [NUM_REGS*8-1:0] regs_flat;
  logic                  err;
  logic                  busy;

  spi_reg_controller #(.NUM_REGS(NUM_REGS), .ID_VALUE(ID_VALUE)) dut (
    .clk       (clk),
    .rst       (rst),
    .cs_n      (cs_n),
    .rx_data   (rx_data),
    .rx_empty  (rx_empty),
    .rx_rd_en  (rx_rd_en),
    .tx_data   (tx_data),
    .tx_full   (tx_full),
    .tx_wr_en  (tx_wr_en),
    .regs_flat (regs_flat),
    .err       (err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // RX source bytes and expected TX bytes; written by the stimulus, consumed by the monitor.
  logic [7:0] src     [256];
  int         src_len = 0;
  logic [7:0] exp_arr [256];
  int         exp_len = 0;

  // Monitor-owned state.
  int         rd_idx = 0;
  int         exp_idx = 0;
  int         pop_cnt = 0, push_cnt = 0, cyc = 0, pop_cyc = 0, push_cyc = 0;
  logic [7:0] last_tx = 8'h00;

  // Register model.
  logic [7:0] m_regs [0:63];
  logic       m_err = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, expv);
    end
  endtask

  // Strobes sampled mid-cycle; the FIFO model reacts just after the edge that accepts them.
  initial begin
    logic pop_pending;
    forever begin
      @(negedge clk);
      cyc++;
      pop_pending = 1'b0;
      if (!rst) begin
        if (rx_rd_en) begin
          check("pop_only_when_nonempty", rx_empty, 0);
          pop_cnt++;
          pop_cyc = cyc;
          pop_pending = 1'b1;
        end
        if (tx_wr_en) begin
          check("push_only_when_not_full", tx_full, 0);
          push_cnt++;
          push_cyc = cyc;
          last_tx  = tx_data;
          if (exp_idx < exp_len) begin
            check("tx_byte", tx_data, exp_arr[exp_idx]);
            exp_idx++;
          end else begin
            check("tx_unexpected_push", exp_idx, exp_len);
          end
        end
      end
      @(posedge clk);
      #1;
      if (pop_pending && rd_idx < src_len) begin
        rx_data = src[rd_idx];
        rd_idx++;
      end
      rx_empty = (rd_idx >= src_len);
    end
  end

  function automatic logic [7:0] model_read(input logic [5:0] a);
    if (a == 6'd0) return ID_VALUE;
    if (int'(a) <= NUM_REGS) return m_regs[a];
    m_err = 1'b1;
    return 8'hFF;
  endfunction

  task automatic model_write(input logic [5:0] a, input logic [7:0] d);
    if (a == 6'd0) m_err = 1'b0;
    else if (int'(a) <= NUM_REGS) m_regs[a] = d;
    else m_err = 1'b1;
  endtask

  task automatic exp_add(input logic [7:0] v);
    exp_arr[exp_len] = v;
    exp_len++;
  endtask

  function automatic logic [NUM_REGS*8-1:0] model_flat();
    logic [NUM_REGS*8-1:0] f;
    for (int n = 1; n <= NUM_REGS; n++) f[(n-1)*8 +: 8] = m_regs[n];
    return f;
  endfunction

  // One frame of up to four bytes; cs_n rises once all expected responses are out.
  task automatic run_frame(input int n, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3, input bit hold);
    logic [7:0] fb [4];
    logic [5:0] a;
    logic       w, bst;
    int         i, k, p0, q0;
    fb[0] = b0; fb[1] = b1; fb[2] = b2; fb[3] = b3;
    i = 0;
    while (i < n) begin
      w = fb[i][7]; bst = fb[i][6]; a = fb[i][5:0];
      i++;
      exp_add(w ? 8'h00 : model_read(a));
      if (bst) begin
        while (i < n) begin
          if (w) begin model_write(a, fb[i]); exp_add(fb[i]); end
          else   exp_add(model_read(a));
          i++;
          a = a + 6'd1;
        end
      end else if (w && i < n) begin
        model_write(a, fb[i]);
        exp_add(fb[i]);
        i++;
      end
    end
    if (hold) tx_full = 1'b1;
    p0 = pop_cnt; q0 = push_cnt;
    for (int j = 0; j < n; j++) begin src[src_len] = fb[j]; src_len++; end
    if (hold) begin
      repeat (10) @(posedge clk);
      check("held_pops", pop_cnt - p0, 1);
      check("held_pushes", push_cnt - q0, 0);
      #2 tx_full = 1'b0;
    end
    k = 0;
    while (exp_idx < exp_len && k < 300) begin @(posedge clk); k++; end
    check("frame_responses_done", exp_idx, exp_len);
    repeat (3) @(posedge clk);
    #2 cs_n = 1'b1;
    repeat (2) @(posedge clk);
    #2 cs_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("busy_after_frame", busy, 0);
    check("err_vs_model", err, m_err);
    check("regs_vs_model", regs_flat, model_flat());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < 64; r++) m_regs[r] = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    check("rst_rx_rd_en", rx_rd_en, 0);
    check("rst_tx_wr_en", tx_wr_en, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_regs", regs_flat, 0);
    rst = 1'b0;
    cs_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;

    run_frame(1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    check("id_literal", last_tx, 8'hA5);
    check("cmd_latency", push_cyc - pop_cyc, 3);

    run_frame(2, 8'h83, 8'h5C, 8'h00, 8'h00, 1'b0);
    check("reg3_literal", regs_flat[23:16], 8'h5C);
    check("data_latency", push_cyc - pop_cyc, 3);
    run_frame(1, 8'h03, 8'h00, 8'h00, 8'h00, 1'b0);
    check("reg3_read_literal", last_tx, 8'h5C);

    run_frame(4, 8'hC1, 8'h11, 8'h22, 8'h33, 1'b0);
    check("burst_regs_literal", regs_flat[23:0], 24'h332211);
    run_frame(4, 8'h41, 8'h00, 8'h00, 8'h00, 1'b0);
    check("burst_read_last_literal", last_tx, 8'h33);

    run_frame(1, 8'h3F, 8'h00, 8'h00, 8'h00, 1'b0);
    check("oor_read_literal", last_tx, 8'hFF);
    check("oor_err_literal", err, 1);
    run_frame(2, 8'h80, 8'h00, 8'h00, 8'h00, 1'b0);
    check("err_clear_literal", err, 0);
    run_frame(1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    check("id_unchanged_literal", last_tx, 8'hA5);

    run_frame(2, 8'h03, 8'h02, 8'h00, 8'h00, 1'b1);
    check("after_hold_literal", last_tx, 8'h22);

    run_frame(2, 8'h85, 8'h77, 8'h00, 8'h00, 1'b0);
    run_frame(1, 8'h85, 8'h00, 8'h00, 8'h00, 1'b0);
    check("abort_reg5_literal", regs_flat[39:32], 8'h77);
    run_frame(1, 8'h05, 8'h00, 8'h00, 8'h00, 1'b0);
    check("abort_read_literal", last_tx, 8'h77);

    run_frame(1, 8'h3F, 8'h00, 8'h00, 8'h00, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("rerst_regs", regs_flat, 0);
    check("rerst_err", err, 0);
    check("rerst_busy", busy, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
